// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the two-port RAM arbiter.
// Holds the arbiter state enum and the default RAM geometry.
package ram_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_e;

    localparam int RAM_AW  = 7;
    localparam int RAM_DW  = 8;
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports: valid_i (requests), last_i (last winner), grant_o (one-hot or zero).
module rr_pick2 (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // On a tie the requester that did not win last goes next.
            2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with burst locking in front of a single-port RAM.
// Ports: req_* request channels, rsp_* read responses, mem_* RAM drive.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW       = RAM_AW,
    parameter int unsigned DW       = RAM_DW,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [NUM_REQ-1:0]    req_lock_i,
    input  logic [NUM_REQ*AW-1:0] req_addr_i,
    input  logic [NUM_REQ*DW-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  mem_we_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [DW-1:0]         mem_wdata_o,
    input  logic [DW-1:0]         mem_rdata_i
);

    localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK);
    // A limit of one means a lock can never extend past its first access.
    localparam bit LOCK_EN = (MAX_LOCK > 1);

    arb_state_e          state_q;
    logic                owner_q;
    logic                last_q;
    logic [3:0]          lock_cnt_q;
    logic [AW-1:0]       addr_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DW-1:0]       rsp_rdata_q;

    logic [NUM_REQ-1:0]  pick;
    logic [NUM_REQ-1:0]  grant;
    logic                any_grant;
    logic                win;
    logic                win_we;
    logic                win_lock;
    logic [AW-1:0]       win_addr;
    logic [DW-1:0]       win_wdata;
    logic                cnt_at_lim;

    rr_pick2 u_pick (
        .valid_i (req_valid_i),
        .last_i  (last_q),
        .grant_o (pick)
    );

    // Ready is forced low while reset is held, whatever the requests do.
    always_comb begin
        grant = '0;
        if (rst_n_i) begin
            if (state_q == IDLE) begin
                grant = pick;
            end else if (owner_q) begin
                grant = {req_valid_i[1], 1'b0};
            end else begin
                grant = {1'b0, req_valid_i[0]};
            end
        end
    end

    assign any_grant  = |grant;
    assign win        = grant[1];
    assign win_we     = req_we_i[win];
    assign win_lock   = req_lock_i[win];
    assign win_addr   = win ? req_addr_i[2*AW-1:AW] : req_addr_i[AW-1:0];
    assign win_wdata  = win ? req_wdata_i[2*DW-1:DW] : req_wdata_i[DW-1:0];
    assign cnt_at_lim = (lock_cnt_q + 4'd1) == LOCK_LIM;

    assign req_ready_o = grant;
    assign mem_we_o    = any_grant & win_we;
    assign mem_addr_o  = any_grant ? win_addr : addr_q;
    assign mem_wdata_o = any_grant ? win_wdata : '0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lock_cnt_q  <= '0;
            addr_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            if (any_grant) begin
                last_q <= win;
                addr_q <= win_addr;
            end
            rsp_valid_q <= (any_grant && !win_we) ? grant : '0;
            if (any_grant && !win_we) begin
                rsp_rdata_q <= mem_rdata_i;
            end
            unique case (state_q)
                IDLE: begin
                    if (any_grant && win_lock && LOCK_EN) begin
                        state_q    <= LOCKED;
                        owner_q    <= win;
                        lock_cnt_q <= 4'd1;
                    end
                end
                LOCKED: begin
                    if (any_grant) begin
                        // last_q already points at the owner, so the
                        // other side wins the next tie after a release.
                        if (!win_lock || cnt_at_lim) begin
                            state_q    <= IDLE;
                            lock_cnt_q <= '0;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 4'd1;
                        end
                    end else if (req_valid_i[~owner_q]) begin
                        state_q    <= IDLE;
                        lock_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a RAM stub and a rule model.
// Ports: none; drives the arbiter and checks every cycle at negedge.
module tb_ram_port_arbiter;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [1:0]    req_lock;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    ram_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_lock_i  (req_lock),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM the arbiter drives.
    logic [DW-1:0] ram [128];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Rule model: who may be granted, what memory must hold, what comes back.
    logic [DW-1:0] ref_mem [128];
    bit            m_locked;
    int            m_owner;
    int            m_last;
    int            m_cnt;
    logic [AW-1:0] m_addr;
    logic [1:0]    exp_rsp_v;
    logic [DW-1:0] exp_rsp_d;

    function automatic logic [1:0] model_grant(logic [1:0] v);
        if (m_locked) return v[m_owner] ? 2'(1 << m_owner) : 2'b00;
        if (v == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] g;
        int w;
        if (!rst_n) begin
            m_locked  = 1'b0;
            m_owner   = 0;
            m_last    = 1;
            m_cnt     = 0;
            m_addr    = '0;
            exp_rsp_v = '0;
            exp_rsp_d = '0;
        end else begin
            g = model_grant(req_valid);
            exp_rsp_v = '0;
            if (g != 2'b00) begin
                w = g[1] ? 1 : 0;
                m_addr = req_addr[w*AW +: AW];
                if (req_we[w]) begin
                    ref_mem[m_addr] = req_wdata[w*DW +: DW];
                end else begin
                    exp_rsp_v = g;
                    exp_rsp_d = ref_mem[m_addr];
                end
                m_last = w;
                if (!m_locked) begin
                    if (req_lock[w] && ML > 1) begin
                        m_locked = 1'b1;
                        m_owner  = w;
                        m_cnt    = 1;
                    end
                end else begin
                    m_cnt++;
                    if (!req_lock[w] || m_cnt == ML) begin
                        m_locked = 1'b0;
                        m_cnt    = 0;
                    end
                end
            end else if (m_locked && req_valid[1-m_owner]) begin
                m_locked = 1'b0;
                m_cnt    = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        int w;
        if (!rst_n) begin
            chk("cmp_rst_ready", req_ready, 0);
            chk("cmp_rst_rspv", rsp_valid, 0);
            chk("cmp_rst_we", mem_we, 0);
        end else begin
            g = model_grant(req_valid);
            w = g[1] ? 1 : 0;
            chk("cmp_ready", req_ready, g);
            chk("cmp_we", mem_we, (g != 0) && req_we[w]);
            chk("cmp_addr", mem_addr,
                (g != 0) ? req_addr[w*AW +: AW] : m_addr);
            if (g != 0 && req_we[w])
                chk("cmp_wdata", mem_wdata, req_wdata[w*DW +: DW]);
            chk("cmp_rspv", rsp_valid, exp_rsp_v);
            if (exp_rsp_v != 0)
                chk("cmp_rdata", rsp_rdata, exp_rsp_d);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int n, bit v, bit w, bit l,
                         logic [AW-1:0] a, logic [DW-1:0] d);
        req_valid[n] = v;
        req_we[n]    = w;
        req_lock[n]  = l;
        req_addr[n*AW +: AW]  = a;
        req_wdata[n*DW +: DW] = d;
    endtask

    task automatic pulse_reset();
        cyc();
        req_valid = '0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] er2 [4];
        logic [1:0] ev2 [4];
        logic [1:0] er3 [6];
        int a0;

        er2 = '{2'b01, 2'b10, 2'b01, 2'b10};
        ev2 = '{2'b00, 2'b01, 2'b10, 2'b01};
        er3 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

        rst_n = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_lock = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 128; i++) begin
            ram[i]     = 8'hA0 ^ 8'(i);
            ref_mem[i] = 8'hA0 ^ 8'(i);
        end

        // Held in reset with both requesting.
        cyc();
        drive(0, 1, 1, 0, 7'h05, 8'h11);
        drive(1, 1, 0, 0, 7'h06, 8'h22);
        #2;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rspv", rsp_valid, 2'b00);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_addr", mem_addr, 7'h00);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_wdata", mem_wdata, 8'h00);
        cyc();
        req_valid = '0;
        rst_n = 1'b1;

        // Single read.
        cyc();
        drive(0, 1, 0, 0, 7'h05, 8'h00);
        #2;
        chk("t1_ready", req_ready, 2'b01);
        chk("t1_addr", mem_addr, 7'h05);
        cyc();
        req_valid = '0;
        #2;
        chk("t1_rspv", rsp_valid, 2'b01);
        chk("t1_rdata", rsp_rdata, 8'hA5);

        // Contention from reset.
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            cyc();
            drive(0, 1, 0, 0, 7'h01, 8'h00);
            drive(1, 1, 0, 0, 7'h02, 8'h00);
            #2;
            chk("t2_ready", req_ready, er2[k]);
            chk("t2_rspv", rsp_valid, ev2[k]);
        end
        cyc();
        req_valid = '0;
        #2;
        chk("t2_rspv_tail", rsp_valid, 2'b10);
        chk("t2_rdata_tail", rsp_rdata, 8'hA2);

        // Lock limit: req0 bursts writes while req1 waits.
        a0 = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            drive(0, 1, 1, 1, 7'(16 + a0), 8'(16 + a0));
            drive(1, 1, 0, 0, 7'h20, 8'h00);
            #2;
            chk("t3_ready", req_ready, er3[k]);
            if (req_ready[0]) a0++;
        end
        cyc();
        req_valid = '0;
        #2;
        chk("t3_hold", req_ready, 2'b00);
        cyc();
        drive(1, 1, 0, 0, 7'h20, 8'h00);
        #2;
        chk("t3_release", req_ready, 2'b00);
        cyc();
        #2;
        chk("t3_req1", req_ready, 2'b10);
        cyc();
        req_valid = '0;
        for (int i = 0; i < 4; i++)
            chk("t3_ram", ram[16+i], 32'(16 + i));

        // Address wrap.
        cyc();
        drive(0, 1, 0, 0, 7'h7F, 8'h00);
        #2;
        chk("t6_ready0", req_ready, 2'b01);
        cyc();
        drive(0, 1, 0, 0, 7'h00, 8'h00);
        #2;
        chk("t6_ready1", req_ready, 2'b01);
        chk("t6_rspv0", rsp_valid, 2'b01);
        chk("t6_rdata0", rsp_rdata, 8'hDF);
        cyc();
        req_valid = '0;
        #2;
        chk("t6_rspv1", rsp_valid, 2'b01);
        chk("t6_rdata1", rsp_rdata, 8'hA0);

        // Write then read back on the next cycle.
        cyc();
        drive(1, 1, 1, 0, 7'h7F, 8'h3C);
        #2;
        chk("t4_wready", req_ready, 2'b10);
        chk("t4_we1", mem_we, 1'b1);
        chk("t4_waddr", mem_addr, 7'h7F);
        chk("t4_wdata", mem_wdata, 8'h3C);
        cyc();
        drive(1, 1, 0, 0, 7'h7F, 8'h00);
        #2;
        chk("t4_rready", req_ready, 2'b10);
        chk("t4_we2", mem_we, 1'b0);
        chk("t4_norsp", rsp_valid, 2'b00);
        cyc();
        req_valid = '0;
        #2;
        chk("t4_rspv", rsp_valid, 2'b10);
        chk("t4_rdata", rsp_rdata, 8'h3C);
        chk("t4_we3", mem_we, 1'b0);

        // Reset in the middle of a locked read burst.
        cyc();
        drive(0, 1, 0, 1, 7'h30, 8'h00);
        #2;
        chk("t5_ready0", req_ready, 2'b01);
        cyc();
        drive(0, 1, 0, 1, 7'h31, 8'h00);
        #2;
        chk("t5_ready1", req_ready, 2'b01);
        chk("t5_rspv", rsp_valid, 2'b01);
        chk("t5_rdata", rsp_rdata, 8'h90);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_ready", req_ready, 2'b00);
        chk("t5_async_rspv", rsp_valid, 2'b00);
        chk("t5_async_rdata", rsp_rdata, 8'h00);
        chk("t5_async_addr", mem_addr, 7'h00);
        chk("t5_async_we", mem_we, 1'b0);
        chk("t5_async_wdata", mem_wdata, 8'h00);
        cyc();
        drive(1, 1, 0, 0, 7'h40, 8'h00);
        #2;
        chk("t5_in_rst_ready", req_ready, 2'b00);
        chk("t5_in_rst_rspv", rsp_valid, 2'b00);
        cyc();
        rst_n = 1'b1;
        drive(0, 1, 0, 0, 7'h31, 8'h00);
        #2;
        chk("t5_tie", req_ready, 2'b01);
        cyc();
        req_valid = '0;
        #2;
        chk("t5_rspv_after", rsp_valid, 2'b01);
        chk("t5_rdata_after", rsp_rdata, 8'h91);

        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
